instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port CS_Ins_load, input, 1 bit: fetch-request strobe from the control FSM.
REQ-004 SHALL have port CS_PC_load, input, 1 bit: copy the PC into the hold register.
REQ-005 SHALL have port CS_PC_inc, input, 1 bit: advance the PC.
REQ-006 SHALL have port rom_req, output, 1 bit: instruction ROM read request.
REQ-007 SHALL have port rom_addr, output, 8 bits: ROM word address.
REQ-008 SHALL have port rom_ack, input, 1 bit: ROM data valid.
REQ-009 SHALL have port rom_data, input, 16 bits: ROM read word.
REQ-010 SHALL have port IF_opcode, output, 4 bits: instruction register [15:12].
REQ-011 SHALL have port IF_rd, output, 3 bits: instruction register [11:9].
REQ-012 SHALL have port IF_rs, output, 3 bits: instruction register [8:6].
REQ-013 SHALL have port IF_imm, output, 16 bits: second word of a 2-word instruction.
REQ-014 SHALL have port IF_pc, output, 8 bits: current PC.
REQ-015 SHALL have port IF_pc_hold, output, 8 bits: PC snapshot taken on CS_PC_load.
REQ-016 SHALL have port IF_valid, output, 1 bit: fetched word is present.
REQ-017 SHALL have port IF_busy, output, 1 bit: ROM transaction in progress.
REQ-018 SHALL have port IF_err, output, 1 bit: sticky fetch timeout flag.

Function
REQ-019 SHALL implement a state machine with states IDLE, FETCH and DONE; IF_busy = 1 exactly in FETCH.
- IDLE -> FETCH: CS_Ins_load = 1 sampled.
- FETCH -> DONE: rom_ack = 1 sampled.
- DONE -> FETCH: CS_Ins_load = 1.
- DONE stays in DONE otherwise.
REQ-020 SHALL drive rom_req = 1 and rom_addr = PC in every FETCH cycle, with rom_addr stable while rom_req = 1.
REQ-021 SHALL, with CS_Ins_load sampled at edge N, raise rom_req after edge N; rom_ack sampled at edge M SHALL update the outputs and drop rom_req after edge M (minimum latency 2 cycles).
REQ-022 SHALL ignore CS_Ins_load while in FETCH.
REQ-023 SHALL write rom_data into the instruction register on ack, unless the word-2 flag is set.
REQ-024 SHALL set the word-2 flag when the loaded opcode is 4'b1100 (MVI) or 4'b1101 (LDA).
REQ-025 SHALL, while the word-2 flag is set, write the next acked word into IF_imm instead of the instruction register, then clear the flag.
REQ-026 SHALL hold IF_opcode, IF_rd and IF_rs unchanged during a word-2 fetch.
REQ-027 SHALL set IF_valid on ack and clear it when a new fetch starts.
REQ-028 SHALL, on CS_PC_inc in IDLE or DONE, set PC = PC+1 mod 256 (0xFF wraps to 0x00).
REQ-029 SHALL, on CS_PC_inc in FETCH, set a pending bit and apply the increment the cycle after ack; a further CS_PC_inc while pending is dropped.
REQ-030 SHALL, on CS_PC_load, set IF_pc_hold = PC pre-increment, regardless of state or a coincident CS_PC_inc.
REQ-031 SHALL, on CS_Ins_load and CS_PC_inc in the same IDLE cycle, fetch from the pre-increment PC.
REQ-032 SHALL give unknown opcodes no special handling; they load as single-word instructions.

Reset
REQ-033 SHALL, on rst_n = 0, immediately force state = IDLE and clear to zero: PC, IF_pc_hold, instruction register, IF_imm, word-2 flag, pending bit, rom_req, IF_valid, IF_busy and IF_err.
REQ-034 SHALL, on reset during FETCH, abandon the transaction and ignore any late rom_ack.

Configuration
REQ-035 SHALL, with macro IFU_FETCH_TIMEOUT_EN defined, count FETCH cycles.
- If rom_ack has not arrived after 16 cycles: return to IDLE, drop rom_req, set IF_err (sticky until reset), leave IF_valid = 0.
- The instruction register is unchanged.
REQ-036 SHALL, without IFU_FETCH_TIMEOUT_EN, tie IF_err to 0 and wait indefinitely in FETCH.

Verification
REQ-037 SHALL cover: reset, CS_Ins_load, ROM acks 0x0A40 in the same cycle -> IF_opcode = 0x0, IF_rd = 5, IF_rs = 1, IF_valid = 1 two cycles after the strobe.
REQ-038 SHALL cover: fetch 0xC600 then a second fetch of 0x1234 -> IF_opcode stays 0xC, IF_imm = 0x1234, word-2 flag cleared.
REQ-039 SHALL cover: PC = 0xFF, CS_PC_inc -> PC = 0x00; CS_PC_load in the same cycle -> IF_pc_hold = 0xFF.
REQ-040 SHALL cover: two CS_PC_inc pulses during a 5-cycle-latency fetch at PC = 3 -> PC = 4 one cycle after ack.
REQ-041 SHALL cover: rst_n low mid-FETCH, then a late ack -> all outputs zero, IF_valid = 0.
REQ-042 SHALL cover, with IFU_FETCH_TIMEOUT_EN defined: no ack for 16 cycles -> rom_req = 0, IF_err = 1, state IDLE.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: IDLE/FETCH/DONE instruction fetcher with PC, hold register and 2-word immediates.
// Optional fetch timeout enabled by defining IFU_FETCH_TIMEOUT_EN.
module instr_fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CS_Ins_load,
  input  logic        CS_PC_load,
  input  logic        CS_PC_inc,
  output logic        rom_req,
  output logic [7:0]  rom_addr,
  input  logic        rom_ack,
  input  logic [15:0] rom_data,
  output logic [3:0]  IF_opcode,
  output logic [2:0]  IF_rd,
  output logic [2:0]  IF_rs,
  output logic [15:0] IF_imm,
  output logic [7:0]  IF_pc,
  output logic [7:0]  IF_pc_hold,
  output logic        IF_valid,
  output logic        IF_busy,
  output logic        IF_err
);
  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] pc_q, pc_d, hold_q, hold_d, addr_q, addr_d;
  logic [9:0] ir_q, ir_d;
  logic [15:0] imm_q, imm_d;
  logic w2_q, w2_d, pend_q, pend_d, valid_q, valid_d;
`ifdef IFU_FETCH_TIMEOUT_EN
  logic [3:0] cnt_q, cnt_d;
  logic err_q, err_d;
`endif
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    w2_d    = w2_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    hold_d  = CS_PC_load ? pc_q : hold_q;
`ifdef IFU_FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    if (state_q == FETCH) begin
      if (CS_PC_inc) pend_d = 1'b1;
      if (rom_ack) begin
        state_d = DONE;
        valid_d = 1'b1;
        if (w2_q) begin
          imm_d = rom_data;
          w2_d  = 1'b0;
        end else begin
          ir_d = rom_data[15:6];
          w2_d = rom_data[15:13] == 3'b110;
        end
      end
`ifdef IFU_FETCH_TIMEOUT_EN
      else if (cnt_q == 4'hF) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else cnt_d = cnt_q + 4'd1;
`endif
    end else begin
      // rom_addr latches the PC before any coincident increment
      if (CS_PC_inc || pend_q) begin
        pc_d   = pc_q + 8'd1;
        pend_d = 1'b0;
      end
      if (CS_Ins_load) begin
        state_d = FETCH;
        addr_d  = pc_q;
        valid_d = 1'b0;
`ifdef IFU_FETCH_TIMEOUT_EN
        cnt_d   = 4'd0;
`endif
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      hold_q  <= '0;
      addr_q  <= '0;
      ir_q    <= '0;
      imm_q   <= '0;
      w2_q    <= 1'b0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef IFU_FETCH_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      w2_q    <= w2_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
`ifdef IFU_FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end
  assign rom_req    = state_q == FETCH;
  assign IF_busy    = state_q == FETCH;
  assign rom_addr   = addr_q;
  assign IF_opcode  = ir_q[9:6];
  assign IF_rd      = ir_q[5:3];
  assign IF_rs      = ir_q[2:0];
  assign IF_imm     = imm_q;
  assign IF_pc      = pc_q;
  assign IF_pc_hold = hold_q;
  assign IF_valid   = valid_q;
`ifdef IFU_FETCH_TIMEOUT_EN
  assign IF_err     = err_q;
`else
  assign IF_err     = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and random checks of instr_fetch_unit against a behavioural model.
module tb_instr_fetch_unit;
  logic clk = 0, rst_n = 0;
  logic CS_Ins_load = 0, CS_PC_load = 0, CS_PC_inc = 0, rom_ack = 0;
  logic [15:0] rom_data = '0;
  logic rom_req, IF_valid, IF_busy, IF_err;
  logic [7:0] rom_addr, IF_pc, IF_pc_hold;
  logic [3:0] IF_opcode;
  logic [2:0] IF_rd, IF_rs;
  logic [15:0] IF_imm;
  int n_vec = 0, n_bad = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .CS_Ins_load(CS_Ins_load), .CS_PC_load(CS_PC_load),
    .CS_PC_inc(CS_PC_inc), .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack),
    .rom_data(rom_data), .IF_opcode(IF_opcode), .IF_rd(IF_rd), .IF_rs(IF_rs),
    .IF_imm(IF_imm), .IF_pc(IF_pc), .IF_pc_hold(IF_pc_hold), .IF_valid(IF_valid),
    .IF_busy(IF_busy), .IF_err(IF_err)
  );

  always #5 clk = ~clk;

  // behavioural model: a fetch is either outstanding or not; PC is an integer mod 256
  int m_fetching, m_pc, m_hold, m_addr, m_op, m_rd, m_rs, m_imm, m_second, m_pend, m_valid, m_err, m_wait;

  task automatic chk(input string tag, input logic [15:0] obs, input int exp);
    n_vec++;
    assert (obs === 16'(exp)) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, 16'(exp));
    end
  endtask

  task automatic model_reset();
    m_fetching = 0; m_pc = 0; m_hold = 0; m_addr = 0; m_op = 0; m_rd = 0; m_rs = 0;
    m_imm = 0; m_second = 0; m_pend = 0; m_valid = 0; m_err = 0; m_wait = 0;
  endtask

  task automatic model_step(input bit ins, input bit inc, input bit ld, input bit ack, input int data);
    int old_pc;
    old_pc = m_pc;
    if (ld) m_hold = m_pc;
    if (m_fetching != 0) begin
      if (inc) m_pend = 1;
      if (ack) begin
        m_fetching = 0;
        m_valid = 1;
        if (m_second != 0) begin
          m_imm = data;
          m_second = 0;
        end else begin
          m_op = data / 4096;
          m_rd = (data / 512) % 8;
          m_rs = (data / 64) % 8;
          m_second = (m_op == 12 || m_op == 13) ? 1 : 0;
        end
      end else begin
        m_wait++;
`ifdef IFU_FETCH_TIMEOUT_EN
        if (m_wait == 16) begin
          m_fetching = 0;
          m_err = 1;
        end
`endif
      end
    end else begin
      if (inc || m_pend != 0) begin
        m_pc = (m_pc + 1) % 256;
        m_pend = 0;
      end
      if (ins) begin
        m_fetching = 1;
        m_addr = old_pc;
        m_valid = 0;
        m_wait = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rom_req"}, 16'(rom_req), m_fetching);
    chk({tag, ".busy"}, 16'(IF_busy), m_fetching);
    if (m_fetching != 0) chk({tag, ".rom_addr"}, 16'(rom_addr), m_addr);
    chk({tag, ".opcode"}, 16'(IF_opcode), m_op);
    chk({tag, ".rd"}, 16'(IF_rd), m_rd);
    chk({tag, ".rs"}, 16'(IF_rs), m_rs);
    chk({tag, ".imm"}, IF_imm, m_imm);
    chk({tag, ".pc"}, 16'(IF_pc), m_pc);
    chk({tag, ".hold"}, 16'(IF_pc_hold), m_hold);
    chk({tag, ".valid"}, 16'(IF_valid), m_valid);
    chk({tag, ".err"}, 16'(IF_err), m_err);
  endtask

  task automatic cyc(input string tag, input bit ins, input bit inc, input bit ld, input bit ack, input logic [15:0] data);
    CS_Ins_load = ins; CS_PC_inc = inc; CS_PC_load = ld; rom_ack = ack; rom_data = data;
    @(posedge clk);
    model_step(ins, inc, ld, ack, int'(data));
    #1 check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 0;
    #1 model_reset();
    check_all(tag);
    #2 rst_n = 1;
  endtask

  initial begin
    model_reset();
    #3 check_all("reset");
    #4 rst_n = 1;
    // single-word fetch with ack on the first FETCH cycle
    cyc("f1.strobe", 1, 0, 0, 1, 16'h0A40);
    chk("f1.req_up", 16'(rom_req), 1);
    cyc("f1.ack", 0, 0, 0, 1, 16'h0A40);
    chk("f1.op", 16'(IF_opcode), 0);
    chk("f1.rd", 16'(IF_rd), 5);
    chk("f1.rs", 16'(IF_rs), 1);
    chk("f1.valid", 16'(IF_valid), 1);
    // two-word MVI, then a plain word to show the word-2 flag cleared
    cyc("mvi.strobe", 1, 0, 0, 0, 16'h0);
    cyc("mvi.ack", 0, 0, 0, 1, 16'hC600);
    cyc("imm.strobe", 1, 0, 0, 0, 16'h0);
    chk("imm.valid_clr", 16'(IF_valid), 0);
    cyc("imm.ack", 0, 0, 0, 1, 16'h1234);
    chk("imm.op_held", 16'(IF_opcode), 4'hC);
    chk("imm.value", IF_imm, 16'h1234);
    cyc("w3.strobe", 1, 0, 0, 0, 16'h0);
    cyc("w3.ack", 0, 0, 0, 1, 16'h2000);
    chk("w3.op", 16'(IF_opcode), 2);
    chk("w3.imm_kept", IF_imm, 16'h1234);
    // PC wrap with coincident hold
    for (int i = 0; i < 255; i++) cyc("incr", 0, 1, 0, 0, 16'h0);
    chk("pc.ff", 16'(IF_pc), 8'hFF);
    cyc("wrap", 0, 1, 1, 0, 16'h0);
    chk("wrap.pc", 16'(IF_pc), 0);
    chk("wrap.hold", 16'(IF_pc_hold), 8'hFF);
    // pending increment during a 5-cycle fetch at PC=3
    for (int i = 0; i < 3; i++) cyc("to3", 0, 1, 0, 0, 16'h0);
    cyc("pend.strobe", 1, 0, 0, 0, 16'h0);
    cyc("pend.w1", 0, 1, 0, 0, 16'h0);
    cyc("pend.w2", 0, 0, 0, 0, 16'h0);
    cyc("pend.w3", 0, 1, 0, 0, 16'h0);
    chk("pend.addr", 16'(rom_addr), 3);
    cyc("pend.ack", 0, 0, 0, 1, 16'h3000);
    chk("pend.pc_at_ack", 16'(IF_pc), 3);
    cyc("pend.after", 0, 0, 0, 0, 16'h0);
    chk("pend.pc", 16'(IF_pc), 4);
    // same-cycle fetch and increment uses the old PC
    cyc("pre.strobe", 1, 1, 0, 0, 16'h0);
    chk("pre.addr", 16'(rom_addr), 4);
    chk("pre.pc", 16'(IF_pc), 5);
    cyc("pre.ack", 0, 0, 0, 1, 16'hF000);
    // reset mid-fetch then a late ack
    cyc("rst.strobe", 1, 0, 0, 0, 16'h0);
    async_reset("rst.mid");
    cyc("rst.late_ack", 0, 0, 0, 1, 16'hFFFF);
    chk("rst.valid", 16'(IF_valid), 0);
    chk("rst.op", 16'(IF_opcode), 0);
`ifdef IFU_FETCH_TIMEOUT_EN
    cyc("to.strobe", 1, 0, 0, 0, 16'h0);
    for (int i = 0; i < 16; i++) cyc("to.wait", 0, 0, 0, 0, 16'h0);
    chk("to.req", 16'(rom_req), 0);
    chk("to.err", 16'(IF_err), 1);
    chk("to.busy", 16'(IF_busy), 0);
    async_reset("to.rst");
`endif
    // random traffic
    for (int i = 0; i < 600; i++)
      cyc("rand", 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0), 16'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
